// File: rtl/dkong_upload_ctrl_if.sv
// HPS ioctl upload port plus the CPU RAM read port, shared by the upload controller
// (slave) and the HPS/RAM side (master).
interface dkong_upload_ctrl_if #(
   parameter int unsigned ADDR_W = 11
);
   localparam int unsigned IOCTL_AW = 25;
   localparam int unsigned DATA_W   = 8;

   logic                  ioctl_upload;
   logic                  ioctl_rd;
   logic [IOCTL_AW-1:0]   ioctl_addr;
   logic [DATA_W-1:0]     ioctl_din;
   logic                  ioctl_wait;
   logic [ADDR_W-1:0]     ram_addr;
   logic                  ram_rd;
   logic                  ram_busy;
   logic [DATA_W-1:0]     ram_q;
   logic                  pause_cpu;
   logic                  upload_active;

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, ram_busy, ram_q,
      input  ioctl_din, ioctl_wait, ram_addr, ram_rd, pause_cpu, upload_active
   );

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, ram_busy, ram_q,
      output ioctl_din, ioctl_wait, ram_addr, ram_rd, pause_cpu, upload_active
   );
endinterface

// File: rtl/dkong_upload_ctrl.sv
// Serves HPS upload reads of the CPU RAM while holding the CPU paused.
// Optional UPLOAD_CHECKSUM_EN exposes a 16-bit byte checksum at addresses SIZE and SIZE+1.
module dkong_upload_ctrl #(
   parameter int unsigned SIZE         = 2048,
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned RAM_LAT      = 1,
   parameter int unsigned PAUSE_CYCLES = 16
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   dkong_upload_ctrl_if.slave   bus
);
   localparam int unsigned IOCTL_AW = 25;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned CNT_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
   localparam int unsigned LAT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   typedef enum logic [2:0] {IDLE, PAUSE, READY, FETCH, LATW, DONE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [LAT_W-1:0]    lat, lat_nxt;
   logic                pend, pend_nxt;
   logic [IOCTL_AW-1:0] pend_addr, pend_addr_nxt;
   logic [IOCTL_AW-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0]   din_q, din_nxt;
   logic                wait_q, wait_nxt;
   logic                ram_rd_q, ram_rd_nxt;
   logic                run_q, run_nxt;
   logic                upload_q;
   logic                start, abort, sample;
   logic [DATA_W-1:0]   oor_data;

   assign start  = (state == IDLE) && bus.ioctl_upload && !upload_q;
   assign abort  = (state != IDLE) && !bus.ioctl_upload;
   assign sample = (state == LATW) && (lat == '0) && !abort;

`ifdef UPLOAD_CHECKSUM_EN
   localparam int unsigned CKS_W = 16;
   logic [CKS_W-1:0] cks;

   // Running sum of every in-range byte served in the current session
   always_ff @(posedge clk_sys) begin
      if (reset)       cks <= '0;
      else if (start)  cks <= '0;
      else if (sample) cks <= cks + CKS_W'(bus.ram_q);
   end

   assign oor_data = (addr_q == IOCTL_AW'(SIZE))     ? cks[7:0]  :
                     (addr_q == IOCTL_AW'(SIZE + 1)) ? cks[15:8] : '0;
`else
   assign oor_data = '0;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat       <= '0;
         pend      <= 1'b0;
         pend_addr <= '0;
         addr_q    <= '0;
         din_q     <= '0;
         wait_q    <= 1'b0;
         ram_rd_q  <= 1'b0;
         run_q     <= 1'b0;
         // a level already high during reset must not look like a new session
         upload_q  <= bus.ioctl_upload;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         lat       <= lat_nxt;
         pend      <= pend_nxt;
         pend_addr <= pend_addr_nxt;
         addr_q    <= addr_nxt;
         din_q     <= din_nxt;
         wait_q    <= wait_nxt;
         ram_rd_q  <= ram_rd_nxt;
         run_q     <= run_nxt;
         upload_q  <= bus.ioctl_upload;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      lat_nxt       = lat;
      pend_nxt      = pend;
      pend_addr_nxt = pend_addr;
      addr_nxt      = addr_q;
      din_nxt       = din_q;
      wait_nxt      = wait_q;
      if (abort) begin
         state_nxt = IDLE;
         pend_nxt  = 1'b0;
         wait_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state_nxt = PAUSE;
               cnt_nxt   = CNT_W'(PAUSE_CYCLES - 1);
               pend_nxt  = 1'b0;
               wait_nxt  = 1'b1;
            end
            PAUSE: begin
               if (bus.ioctl_rd && !pend) begin
                  pend_nxt      = 1'b1;
                  pend_addr_nxt = bus.ioctl_addr;
               end
               if (cnt == '0) begin
                  state_nxt = READY;
                  wait_nxt  = pend_nxt;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            READY: if (pend) begin
               state_nxt = FETCH;
               addr_nxt  = pend_addr;
               pend_nxt  = 1'b0;
               wait_nxt  = 1'b1;
            end else if (bus.ioctl_rd) begin
               state_nxt = FETCH;
               addr_nxt  = bus.ioctl_addr;
               wait_nxt  = 1'b1;
            end
            FETCH: if (addr_q >= IOCTL_AW'(SIZE)) begin
               state_nxt = DONE;
               din_nxt   = oor_data;
               wait_nxt  = 1'b0;
            end else if (!bus.ram_busy) begin
               state_nxt = LATW;
               lat_nxt   = LAT_W'(RAM_LAT - 1);
            end
            LATW: if (lat == '0) begin
               state_nxt = DONE;
               din_nxt   = bus.ram_q;
               wait_nxt  = 1'b0;
            end else begin
               lat_nxt = lat - LAT_W'(1);
            end
            DONE:    state_nxt = READY;
            default: state_nxt = IDLE;
         endcase
      end
      ram_rd_nxt = (state_nxt == FETCH) && (addr_nxt < IOCTL_AW'(SIZE));
      run_nxt    = (state_nxt != IDLE);
   end

   assign bus.ioctl_din     = din_q;
   assign bus.ioctl_wait    = wait_q;
   assign bus.ram_addr      = addr_q[ADDR_W-1:0];
   assign bus.ram_rd        = ram_rd_q;
   assign bus.pause_cpu     = run_q;
   assign bus.upload_active = run_q;
endmodule

// File: tb/tb_dkong_upload_ctrl.sv
// Self-checking bench for dkong_upload_ctrl: table vectors, hand sequences and a
// transaction-level model for randomized reads. Honors UPLOAD_CHECKSUM_EN.
module tb_dkong_upload_ctrl;
   localparam int unsigned SIZE         = 2048;
   localparam int unsigned ADDR_W       = 11;
   localparam int unsigned RAM_LAT      = 1;
   localparam int unsigned PAUSE_CYCLES = 16;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [7:0]  mem [SIZE];
   logic [15:0] m_cks;

   dkong_upload_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   dkong_upload_ctrl #(
      .SIZE(SIZE), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT), .PAUSE_CYCLES(PAUSE_CYCLES)
   ) dut (
      .clk_sys (clk),
      .reset   (reset),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // CPU RAM: one-cycle read latency once the strobe is accepted
   always @(posedge clk)
      if (bus.ram_rd && !bus.ram_busy) bus.ram_q <= mem[bus.ram_addr];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one read from READY; returns in the READY cycle after DONE
   task automatic read_txn(input string tag, input logic [24:0] a, input int nbusy,
                           input logic [7:0] exp_d, input int exp_lat, input int exp_rds,
                           input bit spam, output logic [7:0] got);
      int lat;
      int rds;
      bit addr_bad;
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = a;
      step();
      bus.ioctl_rd   = spam;
      bus.ioctl_addr = spam ? ~a : a;
      chk({tag, "_wait_rise"}, 32'(bus.ioctl_wait), 32'd1);
      lat = 1;
      rds = 0;
      addr_bad = 1'b0;
      while (bus.ioctl_wait && lat < 40) begin
         if (bus.ram_rd) begin
            rds++;
            if (bus.ram_addr !== a[ADDR_W-1:0]) addr_bad = 1'b1;
         end
         bus.ram_busy = (lat <= nbusy);
         step();
         bus.ioctl_rd = 1'b0;
         lat++;
      end
      bus.ram_busy = 1'b0;
      if (bus.ram_rd) rds++;
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_data"}, 32'(bus.ioctl_din), 32'(exp_d));
      chk({tag, "_ram_rd_cycles"}, 32'(rds), 32'(exp_rds));
      chk({tag, "_ram_addr_stable"}, 32'(addr_bad), 32'd0);
      got = bus.ioctl_din;
      bus.ioctl_rd = spam;
      step();
      bus.ioctl_rd = 1'b0;
      if (spam) chk({tag, "_done_rd_ignored"}, 32'(bus.ioctl_wait), 32'd0);
   endtask

   // Reference: data and timing derived from address class alone
   task automatic model_read(input string tag, input logic [24:0] a, input int nbusy, input bit spam);
      logic [7:0] e;
      logic [7:0] got;
      bit inr;
      inr = (a < 25'(SIZE));
      e = 8'h00;
      if (inr) e = mem[a[ADDR_W-1:0]];
`ifdef UPLOAD_CHECKSUM_EN
      else if (a == 25'(SIZE))     e = m_cks[7:0];
      else if (a == 25'(SIZE + 1)) e = m_cks[15:8];
`endif
      read_txn(tag, a, nbusy, e, inr ? 2 + int'(RAM_LAT) + nbusy : 2, inr ? 1 + nbusy : 0, spam, got);
      if (inr) m_cks = m_cks + 16'(e);
   endtask

   task automatic start_session(input string tag);
      bus.ioctl_upload = 1'b1;
      step();
      chk({tag, "_pause_cpu"}, 32'(bus.pause_cpu), 32'd1);
      chk({tag, "_active"}, 32'(bus.upload_active), 32'd1);
      chk({tag, "_wait_in_pause"}, 32'(bus.ioctl_wait), 32'd1);
      repeat (PAUSE_CYCLES - 1) step();
      chk({tag, "_wait_last_pause"}, 32'(bus.ioctl_wait), 32'd1);
      step();
      chk({tag, "_wait_ready"}, 32'(bus.ioctl_wait), 32'd0);
      m_cks = '0;
   endtask

   typedef struct {
      logic [24:0] addr;
      int          nbusy;
      logic [7:0]  data;
      int          lat;
      int          rds;
      bit          spam;
   } vec_t;

   vec_t       tbl [8];
   logic [7:0] got;
   logic [7:0] exp_lo;
   logic [24:0] ra;

   initial begin
      for (int i = 0; i < int'(SIZE); i++) mem[i] = 8'($urandom);
      mem[0] = 8'h3C; mem[5] = 8'hA5; mem[7] = 8'h77; mem[SIZE-1] = 8'h5A;

      tbl[0] = '{25'h000005, 0, 8'hA5, 3, 1, 1'b0};
      tbl[1] = '{25'h000005, 3, 8'hA5, 6, 4, 1'b0};
      tbl[2] = '{25'h0007FF, 1, 8'h5A, 4, 2, 1'b1};
      tbl[3] = '{25'h000000, 2, 8'h3C, 5, 3, 1'b0};
      tbl[4] = '{25'h800000, 0, 8'h00, 2, 0, 1'b0};
      tbl[5] = '{25'h001005, 2, 8'h00, 2, 0, 1'b0};
      tbl[6] = '{25'h1FFFFFF, 0, 8'h00, 2, 0, 1'b1};
      tbl[7] = '{25'h000802, 1, 8'h00, 2, 0, 1'b0};

      reset = 1'b1;
      bus.ioctl_upload = 1'b0;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_addr   = '0;
      bus.ram_busy     = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_din", 32'(bus.ioctl_din), 32'd0);
      chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("rst_ram_rd", 32'(bus.ram_rd), 32'd0);
      chk("rst_pause", 32'(bus.pause_cpu), 32'd0);
      chk("rst_active", 32'(bus.upload_active), 32'd0);

      // Early read during PAUSE, then abort in LATW
      bus.ioctl_upload = 1'b1;
      step();
      chk("early_pause_c1", 32'(bus.pause_cpu), 32'd1);
      step(); step();
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h5;
      step();
      bus.ioctl_rd = 1'b0; bus.ioctl_addr = 25'h0;
      repeat (PAUSE_CYCLES - 4) step();
      chk("early_wait_c16", 32'(bus.ioctl_wait), 32'd1);
      step();
      chk("early_wait_held_ready", 32'(bus.ioctl_wait), 32'd1);
      step();
      chk("early_ram_rd", 32'(bus.ram_rd), 32'd1);
      chk("early_ram_addr", 32'(bus.ram_addr), 32'h5);
      step(); step();
      chk("early_wait_done", 32'(bus.ioctl_wait), 32'd0);
      chk("early_data", 32'(bus.ioctl_din), 32'hA5);
      step();
      chk("early_served_once", 32'(bus.ioctl_wait), 32'd0);
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h7;
      step();
      bus.ioctl_rd = 1'b0;
      chk("abort_fetch_rd", 32'(bus.ram_rd), 32'd1);
      step();
      bus.ioctl_upload = 1'b0;
      step();
      chk("abort_pause", 32'(bus.pause_cpu), 32'd0);
      chk("abort_ram_rd", 32'(bus.ram_rd), 32'd0);
      chk("abort_active", 32'(bus.upload_active), 32'd0);
      chk("abort_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("abort_din_kept", 32'(bus.ioctl_din), 32'hA5);
      step();

      // Table-driven reads
      start_session("tbl_start");
      for (int i = 0; i < 8; i++)
         read_txn($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].nbusy, tbl[i].data,
                  tbl[i].lat, tbl[i].rds, tbl[i].spam, got);

      // Reset mid-session with upload held high
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      chk("midrst_din", 32'(bus.ioctl_din), 32'd0);
      chk("midrst_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("midrst_pause", 32'(bus.pause_cpu), 32'd0);
      repeat (3) step();
      chk("midrst_no_restart", 32'(bus.pause_cpu), 32'd0);
      chk("midrst_no_active", 32'(bus.upload_active), 32'd0);
      bus.ioctl_upload = 1'b0;
      step();

      // Randomized reads against the model
      for (int i = 0; i < int'(SIZE); i++) mem[i] = 8'($urandom);
      start_session("rnd_start");
      for (int k = 0; k < 200; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: ra = 25'($urandom_range(0, SIZE - 1));
            6:       ra = 25'(SIZE - 1);
            7:       ra = 25'(SIZE + $urandom_range(0, 1));
            default: begin
               ra = 25'($urandom);
               if (ra < 25'(SIZE + 2)) ra = ra + 25'h1000;
            end
         endcase
         repeat ($urandom_range(0, 2)) step();
         model_read($sformatf("rnd%0d", k), ra, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      end
      bus.ioctl_upload = 1'b0;
      step();
      chk("rnd_end_pause", 32'(bus.pause_cpu), 32'd0);

      // Checksum sweep over the full RAM then the two trailer addresses
      for (int i = 0; i < int'(SIZE); i++) mem[i] = (i < 16) ? 8'(i + 1) : 8'h00;
      step();
      start_session("cks_start");
      for (int i = 0; i < int'(SIZE); i++) model_read($sformatf("cks%0d", i), 25'(i), 0, 1'b0);
`ifdef UPLOAD_CHECKSUM_EN
      exp_lo = 8'h88;
`else
      exp_lo = 8'h00;
`endif
      read_txn("cks_lo", 25'(SIZE), 0, exp_lo, 2, 0, 1'b0, got);
      read_txn("cks_hi", 25'(SIZE + 1), 0, 8'h00, 2, 0, 1'b0, got);
      bus.ioctl_upload = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
